multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM for a multi-cycle CPU (IF/ID/EXE/MEM/WB).
// Define MULTI_CYCLE_CTRL_HALT_EN to add the HALT state entered by opcode 111111.
module multi_cycle_ctrl (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       IRWre,
   output logic       RegWre,
   output logic       MemWre,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [2:0] State
);
   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
`ifdef MULTI_CYCLE_CTRL_HALT_EN
      S_WB   = 3'b100,
      S_HALT = 3'b101
`else
      S_WB   = 3'b100
`endif
   } state_t;
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_J    = 6'b111000;
   state_t st;
   logic op_add, op_sub, op_addi, op_or, op_and, op_ori;
   logic op_sw, op_lw, op_beq, op_j, op_halt, op_alu, op_unk;
   logic in_if, in_id, in_exe, in_mem, in_wb;
   assign op_add  = Opcode == OP_ADD;
   assign op_sub  = Opcode == OP_SUB;
   assign op_addi = Opcode == OP_ADDI;
   assign op_or   = Opcode == OP_OR;
   assign op_and  = Opcode == OP_AND;
   assign op_ori  = Opcode == OP_ORI;
   assign op_sw   = Opcode == OP_SW;
   assign op_lw   = Opcode == OP_LW;
   assign op_beq  = Opcode == OP_BEQ;
   assign op_j    = Opcode == OP_J;
`ifdef MULTI_CYCLE_CTRL_HALT_EN
   assign op_halt = Opcode == 6'b111111;
`else
   assign op_halt = 1'b0;
`endif
   assign op_alu = op_add | op_sub | op_addi | op_or | op_and | op_ori;
   assign op_unk = !(op_alu | op_sw | op_lw | op_beq | op_j | op_halt);
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) st <= S_IF;
      else
         case (st)
            S_IF:  st <= S_ID;
`ifdef MULTI_CYCLE_CTRL_HALT_EN
            S_ID:  st <= op_halt ? S_HALT : (op_j | op_unk) ? S_IF : S_EXE;
            S_HALT: st <= S_HALT;
`else
            S_ID:  st <= (op_j | op_unk) ? S_IF : S_EXE;
`endif
            S_EXE: st <= op_beq ? S_IF : (op_lw | op_sw) ? S_MEM : S_WB;
            S_MEM: st <= op_lw ? S_WB : S_IF;
            S_WB:  st <= S_IF;
            default: st <= S_IF;
         endcase
   assign in_if  = st == S_IF;
   assign in_id  = st == S_ID;
   assign in_exe = st == S_EXE;
   assign in_mem = st == S_MEM;
   assign in_wb  = st == S_WB;
   // Outputs are decoded from the current state and forced low while in reset.
   assign State   = st;
   assign IRWre   = Reset & in_if;
   assign RegWre  = Reset & in_wb;
   assign MemWre  = Reset & in_mem & op_sw;
   assign ALUSrcB = Reset & in_exe & (op_addi | op_ori | op_lw | op_sw);
   assign PCWre   = Reset & ((in_id & (op_j | op_unk)) | (in_exe & op_beq) | (in_mem & op_sw) | in_wb);
   assign PCSrc   = !Reset ? 2'b00 : (in_id & op_j) ? 2'b10 : (in_exe & op_beq & Zero) ? 2'b01 : 2'b00;
   assign ALUOp   = !(Reset & in_exe) ? 3'b000 : (op_sub | op_beq) ? 3'b001 :
                    (op_or | op_ori) ? 3'b010 : op_and ? 3'b011 : 3'b000;
endmodule
